// File: rtl/tick_scheduler_if.sv
// Configuration write port of tick_scheduler: valid/ready handshake carrying
// a register select and a period in base ticks.
interface tick_scheduler_if;
  logic        cfg_valid;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_period;
  logic        cfg_ready;

  modport master (output cfg_valid, output cfg_sel, output cfg_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_sel, input cfg_period, output cfg_ready);
endinterface

// File: rtl/tick_scheduler.sv
// FlappyBird timing controller: one prescaler, clock-enable pulses for physics/scroll/blink.
// Build option: define TICK_SCHED_BLINK_EN to include the blink channel (tick_blink tied low otherwise).
module tick_scheduler #(
  parameter int unsigned PRESCALE   = 50_000,
  parameter int unsigned PHYS_DEF   = 20,
  parameter int unsigned SCROLL_DEF = 40,
  parameter int unsigned BLINK_DEF  = 500,
  parameter int unsigned SPEED_STEP = 2,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic            clock_in,
  input  logic            reset,
  input  logic            start,
  input  logic            pause,
  input  logic            stop,
  input  logic            speed_up,
  tick_scheduler_if.slave cfg,
  output logic            base_tick,
  output logic            tick_phys,
  output logic            tick_scroll,
  output logic            tick_blink,
  output logic [1:0]      state,
  output logic [3:0]      speed_level
);

  localparam int unsigned   PW          = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
  localparam logic [15:0]   STEP        = 16'(SPEED_STEP);
  localparam logic [15:0]   FLOOR       = 16'(MIN_PERIOD);
  localparam logic [16:0]   STEP_FLOOR  = 17'(MIN_PERIOD) + 17'(SPEED_STEP);

  if (PRESCALE < 2 || PHYS_DEF == 0 || SCROLL_DEF == 0 || BLINK_DEF == 0 || MIN_PERIOD == 0)
  begin : g_bad_params
    $error("tick_scheduler: PRESCALE must be >= 2 and all periods >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          run_start, halt;
  logic          run_adv, speed_ok;
  logic          cfg_wr;
  logic [15:0]   cfg_val;
  logic [PW-1:0] presc;
  logic [15:0]   phys_per, scroll_base, scroll_eff;
  logic [15:0]   phys_cnt, scroll_cnt;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    halt      = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      halt    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  if (start) begin
                   state_d   = S_RUN;
                   run_start = 1'b1;
                 end
        S_RUN:   if (pause) state_d = S_PAUSE;
        S_PAUSE: if (pause) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state         = state_q;
  assign cfg.cfg_ready = (state_q != S_RUN);
  assign cfg_wr        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_val       = (cfg.cfg_period == 16'd0) ? 16'd1 : cfg.cfg_period;
  assign run_adv       = base_tick && (state_q == S_RUN);
  assign speed_ok      = speed_up && (state_q == S_RUN) && !stop;

  // Clearing base_tick on the start edge pins the first channel advance to
  // exactly PRESCALE+1 edges after start, whatever the prescaler phase was.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      base_tick <= 1'b0;
    end else if (run_start) begin
      presc     <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (presc == PRE_LAST);
      presc     <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      phys_per    <= 16'(PHYS_DEF);
      scroll_base <= 16'(SCROLL_DEF);
    end else if (cfg_wr) begin
      case (cfg.cfg_sel)
        2'd0:    phys_per    <= cfg_val;
        2'd1:    scroll_base <= cfg_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      scroll_eff  <= 16'(SCROLL_DEF);
      speed_level <= '0;
    end else if (run_start) begin
      scroll_eff  <= scroll_base;
      speed_level <= '0;
    end else if (speed_ok) begin
      scroll_eff  <= ({1'b0, scroll_eff} >= STEP_FLOOR) ? scroll_eff - STEP : FLOOR;
      if (speed_level != 4'hF) speed_level <= speed_level + 4'd1;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      phys_cnt  <= '0;
      tick_phys <= 1'b0;
    end else begin
      tick_phys <= 1'b0;
      if (run_start || halt) begin
        phys_cnt <= '0;
      end else if (run_adv) begin
        if (phys_cnt >= phys_per - 16'd1) begin
          phys_cnt  <= '0;
          tick_phys <= 1'b1;
        end else begin
          phys_cnt <= phys_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      scroll_cnt  <= '0;
      tick_scroll <= 1'b0;
    end else begin
      tick_scroll <= 1'b0;
      if (run_start || halt) begin
        scroll_cnt <= '0;
      end else if (run_adv) begin
        if (scroll_cnt >= scroll_eff - 16'd1) begin
          scroll_cnt  <= '0;
          tick_scroll <= 1'b1;
        end else begin
          scroll_cnt <= scroll_cnt + 16'd1;
        end
      end
    end
  end

`ifdef TICK_SCHED_BLINK_EN
  logic [15:0] blink_per, blink_cnt;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      blink_per  <= 16'(BLINK_DEF);
      blink_cnt  <= '0;
      tick_blink <= 1'b0;
    end else begin
      tick_blink <= 1'b0;
      if (cfg_wr && cfg.cfg_sel == 2'd2) blink_per <= cfg_val;
      if (base_tick) begin
        if (blink_cnt >= blink_per - 16'd1) begin
          blink_cnt  <= '0;
          tick_blink <= 1'b1;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign tick_blink = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: expected tick cycles are queued as
// stimulus is applied and consumed by a negedge monitor as pulses appear.
module tb_tick_scheduler;
  localparam int PS    = 4;
  localparam int PHYS  = 3;
  localparam int SCR   = 8;
  localparam int BLINK = 5;
`ifdef TICK_SCHED_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       stop     = 1'b0;
  logic       speed_up = 1'b0;
  logic       base_tick, tick_phys, tick_scroll, tick_blink;
  logic [1:0] state;
  logic [3:0] speed_level;

  tick_scheduler_if cfg_bus ();

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_phys[$];
  int exp_scroll[$];
  bit mon_phys   = 1'b0;
  bit mon_scroll = 1'b0;
  bit due_p, due_s;

  tick_scheduler #(
    .PRESCALE  (PS),
    .PHYS_DEF  (PHYS),
    .SCROLL_DEF(SCR),
    .BLINK_DEF (BLINK),
    .SPEED_STEP(2),
    .MIN_PERIOD(4)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .speed_up   (speed_up),
    .cfg        (cfg_bus),
    .base_tick  (base_tick),
    .tick_phys  (tick_phys),
    .tick_scroll(tick_scroll),
    .tick_blink (tick_blink),
    .state      (state),
    .speed_level(speed_level)
  );

  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;

  // Scoreboard consumer: cyc is the number of the edge that produced the current outputs.
  always @(negedge clock_in) begin
    if (mon_phys) begin
      due_p = (exp_phys.size() > 0) && (exp_phys[0] == cyc);
      if (due_p || tick_phys) begin
        checks++;
        if (tick_phys !== due_p) begin
          errors++;
          $display("FAIL phys_tick at cycle %0d: got %0b required %0b", cyc, tick_phys, due_p);
        end
        if (due_p) void'(exp_phys.pop_front());
      end
    end
    if (mon_scroll) begin
      due_s = (exp_scroll.size() > 0) && (exp_scroll[0] == cyc);
      if (due_s || tick_scroll) begin
        checks++;
        if (tick_scroll !== due_s) begin
          errors++;
          $display("FAIL scroll_tick at cycle %0d: got %0b required %0b", cyc, tick_scroll, due_s);
        end
        if (due_s) void'(exp_scroll.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock_in);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // which: 0 start, 1 pause, 2 stop, 3 speed_up; edge_no is the sampling edge.
  task automatic pulse(input int which, output int edge_no);
    edge_no = cyc + 1;
    case (which)
      0:       start    = 1'b1;
      1:       pause    = 1'b1;
      2:       stop     = 1'b1;
      default: speed_up = 1'b1;
    endcase
    step();
    start = 1'b0; pause = 1'b0; stop = 1'b0; speed_up = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] per);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_sel    = sel;
    cfg_bus.cfg_period = per;
    step();
    cfg_bus.cfg_valid  = 1'b0;
  endtask

  // Channel started at edge k with constant period per; advance edges are
  // k + PS*j + 1, except those in the pause window (p, r].
  task automatic push_ticks(input bit scr, input int k, input int per,
                            input int p, input int r, input int horizon);
    int n, e;
    n = 0;
    for (int j = 1; k + PS * j + 1 <= horizon; j++) begin
      e = k + PS * j + 1;
      if (!(e > p && e <= r)) begin
        n++;
        if (n % per == 0) begin
          if (scr) exp_scroll.push_back(e);
          else     exp_phys.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_period = 16'd0;
    repeat (3) step();
    checks++;
    if ({base_tick, tick_phys, tick_scroll, tick_blink} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ticks: got %b required 0000", {base_tick, tick_phys, tick_scroll, tick_blink});
    end
    checks++;
    if ({state, cfg_bus.cfg_ready, speed_level} !== 7'b00_1_0000) begin
      errors++;
      $display("FAIL reset_state: got state=%0d ready=%0b level=%0d required 0 1 0", state, cfg_bus.cfg_ready, speed_level);
    end
    reset = 1'b0;
    repeat (8) step();
    cnt = 0;
    repeat (10 * PS) begin
      step();
      if (base_tick) cnt++;
    end
    checks++;
    if (cnt !== 10) begin
      errors++;
      $display("FAIL base_tick_rate: got %0d pulses required 10", cnt);
    end
  endtask

  task automatic test_phys_timing();
    int k;
    pulse(0, k);
    checks++;
    if (state !== 2'd1 || cfg_bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_run: got state=%0d ready=%0b required 1 0", state, cfg_bus.cfg_ready);
    end
    push_ticks(1'b0, k, PHYS, 0, 0, k + 55);
    mon_phys = 1'b1;
    wait_until(k + 55);
    mon_phys = 1'b0;
    checks++;
    if (exp_phys.size() !== 0) begin
      errors++;
      $display("FAIL phys_missing: got %0d outstanding required 0", exp_phys.size());
    end
  endtask

  task automatic test_pause();
    int k, p, r, cnt;
    bit ok;
    pulse(2, k);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL stop_idle: got %0d required 0", state);
    end
    pulse(0, k);
    push_ticks(1'b0, k, PHYS, k + 18, k + 41, k + 70);
    push_ticks(1'b1, k, SCR,  k + 18, k + 41, k + 70);
    mon_phys = 1'b1; mon_scroll = 1'b1;
    wait_until(k + 17);
    pulse(1, p);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_state: got %0d required 2", state);
    end
    cnt = 0;
    while (cyc < k + 40) begin
      step();
      if (tick_blink) cnt++;
    end
    pulse(1, r);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL resume_state: got %0d required 1", state);
    end
    wait_until(k + 70);
    mon_phys = 1'b0; mon_scroll = 1'b0;
    checks++;
    if (exp_phys.size() + exp_scroll.size() !== 0) begin
      errors++;
      $display("FAIL pause_missing: got %0d outstanding required 0", exp_phys.size() + exp_scroll.size());
    end
    ok = BLINK_ON ? (cnt >= 1) : (cnt == 0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_in_pause: got %0d pulses required %s", cnt, BLINK_ON ? ">=1" : "0");
    end
  endtask

  task automatic test_cfg();
    int k;
    pulse(2, k);
    checks++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready_idle: got %0b required 1", cfg_bus.cfg_ready);
    end
    cfg_write(2'd1, 16'd10);
    cfg_write(2'd3, 16'd1);
    pulse(0, k);
    checks++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ready_run: got %0b required 0", cfg_bus.cfg_ready);
    end
    push_ticks(1'b0, k, PHYS, 0, 0, k + 90);
    push_ticks(1'b1, k, 10,   0, 0, k + 90);
    mon_phys = 1'b1; mon_scroll = 1'b1;
    cfg_write(2'd0, 16'd1);
    wait_until(k + 90);
    mon_phys = 1'b0; mon_scroll = 1'b0;
    checks++;
    if (exp_phys.size() + exp_scroll.size() !== 0) begin
      errors++;
      $display("FAIL cfg_missing: got %0d outstanding required 0", exp_phys.size() + exp_scroll.size());
    end
  endtask

  task automatic test_speed_up();
    int k, e;
    pulse(2, k);
    cfg_write(2'd1, 16'd8);
    pulse(0, k);
    mon_scroll = 1'b1;
    exp_scroll.push_back(k + 33);
    wait_until(k + 33);
    pulse(3, e);
    exp_scroll.push_back(k + 33 + 6 * PS);
    wait_until(k + 57);
    pulse(3, e);
    exp_scroll.push_back(k + 57 + 4 * PS);
    wait_until(k + 73);
    pulse(3, e);
    exp_scroll.push_back(k + 73 + 4 * PS);
    exp_scroll.push_back(k + 73 + 8 * PS);
    wait_until(k + 105);
    mon_scroll = 1'b0;
    checks++;
    if (exp_scroll.size() !== 0) begin
      errors++;
      $display("FAIL speed_missing: got %0d outstanding required 0", exp_scroll.size());
    end
    checks++;
    if (speed_level !== 4'd3) begin
      errors++;
      $display("FAIL speed_level3: got %0d required 3", speed_level);
    end
    repeat (12) begin
      pulse(3, e);
      step();
    end
    checks++;
    if (speed_level !== 4'd15) begin
      errors++;
      $display("FAIL speed_level15: got %0d required 15", speed_level);
    end
    pulse(3, e);
    checks++;
    if (speed_level !== 4'd15) begin
      errors++;
      $display("FAIL speed_saturate: got %0d required 15", speed_level);
    end
    pulse(2, k);
    pulse(0, k);
    checks++;
    if (speed_level !== 4'd0) begin
      errors++;
      $display("FAIL speed_cleared: got %0d required 0", speed_level);
    end
    push_ticks(1'b1, k, SCR, 0, 0, k + 70);
    mon_scroll = 1'b1;
    wait_until(k + 70);
    mon_scroll = 1'b0;
    checks++;
    if (exp_scroll.size() !== 0) begin
      errors++;
      $display("FAIL speed_restore: got %0d outstanding required 0", exp_scroll.size());
    end
  endtask

  task automatic test_stop_start();
    int k;
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL stop_over_start: got %0d required 0", state);
    end
    cfg_write(2'd0, 16'd0);
    pulse(0, k);
    push_ticks(1'b0, k, 1, 0, 0, k + 40);
    mon_phys = 1'b1;
    wait_until(k + 40);
    mon_phys = 1'b0;
    checks++;
    if (exp_phys.size() !== 0) begin
      errors++;
      $display("FAIL phys_period0: got %0d outstanding required 0", exp_phys.size());
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (tick_scroll) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scroll_wait: got no tick_scroll in 80 cycles required one");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({base_tick, tick_phys, tick_scroll, tick_blink} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_ticks: got %b required 0000", {base_tick, tick_phys, tick_scroll, tick_blink});
    end
    checks++;
    if ({state, cfg_bus.cfg_ready, speed_level} !== 7'b00_1_0000) begin
      errors++;
      $display("FAIL async_reset_state: got state=%0d ready=%0b level=%0d required 0 1 0", state, cfg_bus.cfg_ready, speed_level);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_blink();
    int cnt, want;
`ifndef TICK_SCHED_BLINK_EN
    cfg_write(2'd2, 16'd1);
`endif
    repeat (30) step();
    cnt = 0;
    repeat (10 * BLINK * PS) begin
      step();
      if (tick_blink) cnt++;
    end
    want = BLINK_ON ? 10 : 0;
    checks++;
    if (cnt !== want) begin
      errors++;
      $display("FAIL blink_count: got %0d pulses required %0d", cnt, want);
    end
  endtask

  initial begin
    test_reset();
    test_phys_timing();
    test_pause();
    test_cfg();
    test_speed_up();
    test_stop_start();
    test_reset_midrun();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Central timing controller for the FlappyBird game logic. It divides `clock_in` with one free-running prescaler and issues single-cycle enable pulses to three consumers: bird physics, pipe scroll and the LED/blink indicator. Consumers stay on `clock_in` and use these enables, so the design has no derived clocks. The block runs an IDLE/RUN/PAUSE state machine, accepts period configuration through a valid/ready port, and shortens the scroll period on speed-up requests.

## Interface
- PRESCALE, 50_000: `clock_in` cycles per base tick (1 kHz at 50 MHz); must be ≥ 2.
- PHYS_DEF, 20: reset period of the physics channel, in base ticks.
- SCROLL_DEF, 40: reset base period of the scroll channel, in base ticks.
- BLINK_DEF, 500: reset period of the blink channel, in base ticks.
- SPEED_STEP, 2: base ticks removed from the scroll period per `speed_up`.
- MIN_PERIOD, 4: floor for the scroll period.

Ports:
- clock_in  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level sampled each edge; IDLE→RUN.
- pause  in  1  single-cycle pulse; toggles RUN↔PAUSE.
- stop  in  1  level; any state→IDLE.
- speed_up  in  1  single-cycle pulse; honoured in RUN only.
- cfg_valid  in  1  configuration write request.
- cfg_sel  in  2  0=phys, 1=scroll base, 2=blink, 3=ignored.
- cfg_period  in  16  new period in base ticks.
- cfg_ready  out  1  1 in IDLE and PAUSE, 0 in RUN.
- base_tick  out  1  registered 1-cycle pulse, every PRESCALE cycles.
- tick_phys  out  1  registered 1-cycle physics enable.
- tick_scroll  out  1  registered 1-cycle scroll enable.
- tick_blink  out  1  registered 1-cycle blink enable.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE.
- speed_level  out  4  count of accepted speed_up pulses; saturates at 15.

## Operation
Reset values:
- state=IDLE, cfg_ready=1.
- All tick outputs and base_tick = 0.
- speed_level=0, prescaler=0, all channel counters=0.
- Period registers = *_DEF; effective scroll period = SCROLL_DEF.

FSM:
- Command priority: stop > start > pause.
- IDLE→RUN on start. On this edge the prescaler, phys counter and scroll counter clear, effective scroll period reloads from the scroll base, and speed_level clears.
- RUN→PAUSE on pause. PAUSE→RUN on pause.
- start in RUN or PAUSE: ignored.
- stop in any state → IDLE; clears the phys and scroll counters.

Prescaler and base tick:
- The prescaler counts 0..PRESCALE-1 and wraps. It runs in every state.
- base_tick is registered high for the cycle after the wrap edge.

Channels:
- Each channel counter advances on edges where base_tick=1.
- When count ≥ period-1, the counter reloads to 0 and the channel's tick output is registered high. Using ≥ means a period shortened below the current count fires on the next base tick.
- phys and scroll advance in RUN only; in PAUSE they hold their count.
- blink advances in all states.
- Pause freezes phys/scroll phase to base-tick granularity. Up to PRESCALE-1 cycles of prescaler phase drift across a pause is accepted.

Configuration:
- A write is accepted when cfg_valid && cfg_ready. It updates the selected register on that edge.
- cfg_period=0 is stored as 1. cfg_sel=3 is accepted and discarded.
- A scroll write changes the base only. The effective scroll period is reloaded from the base on the next start.

Speed-up:
- In RUN, speed_up sets effective scroll = max(eff − SPEED_STEP, MIN_PERIOD) and increments speed_level, saturating at 15.
- A speed_up that leaves the period at MIN_PERIOD still increments speed_level up to 15.

## Timing
- Start sampled at edge k: tick_phys first goes high in the cycle after edge k + P·PRESCALE + 1, where P = phys period. Subsequent pulses are every P·PRESCALE cycles.
- Every tick output is exactly one cycle wide.
- cfg handshake: accepted in the same cycle; there is no back-pressure beyond cfg_ready.
- Reset asserted mid-operation forces the reset values immediately, asynchronously, including any in-flight tick.

## Configuration
- Macro TICK_SCHED_BLINK_EN.
- Defined: the blink channel is present as described above.
- Undefined: no blink counter is built and tick_blink is tied to 0. cfg_sel=2 writes are accepted and discarded.

## Test plan
- Reset with PRESCALE=4, PHYS_DEF=3: all outputs 0, state=0, cfg_ready=1. Pulse start at edge k: tick_phys is high only in the cycle after edge k+13, then every 12 cycles.
- In RUN, pulse pause: state=2, tick_phys and tick_scroll stay 0 while tick_blink continues. Pulse pause again: state=1 and the phys count resumes from its held value.
- In IDLE, write cfg_sel=1, cfg_period=10: cfg_ready=1 and the write is accepted. Start: tick_scroll period = 10·PRESCALE. cfg_valid during RUN: no change.
- SCROLL_DEF=8, SPEED_STEP=2, MIN_PERIOD=4, apply 3 speed_up pulses: effective periods 6, 4, 4; speed_level=3. stop then start: period back to 8, speed_level=0.
- Assert stop and start together in RUN: state=IDLE. cfg_period=0 to phys: stored as 1, so tick_phys fires on every base_tick.
- Assert reset while tick_scroll is high: tick_scroll drops the same cycle and all outputs return to their reset values. With TICK_SCHED_BLINK_EN undefined, tick_blink stays 0 for 10·BLINK_DEF base ticks.
